// File: rtl/instr_encoder_loader.sv
// Encodes RV32I instruction requests into 32-bit words and writes them sequentially
// into an instruction memory, one word every two cycles, until DEPTH words are stored.
module instr_encoder_loader #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          restart,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    iclass,
  input  logic [4:0]    rd,
  input  logic [4:0]    rs1,
  input  logic [4:0]    rs2,
  input  logic [2:0]    funct3,
  input  logic [6:0]    funct7,
  input  logic [31:0]   imm,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [AW:0]   count,
  output logic          full,
  output logic          err
);

  typedef enum logic [1:0] {IDLE, WRITE, REJECT} state_t;

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  state_t      state, state_nxt;
  logic [AW:0] count_nxt;
  logic [31:0] word, word_nxt;
  logic [31:0] enc;
  logic        misaligned;
  logic        accept;

  // NOTE: every always_comb output gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    enc = '0;
    unique case (iclass)
      3'd0: enc = {funct7, rs2, rs1, funct3, rd, 7'b0110011};
      3'd1: begin
        enc = {imm[11:0], rs1, funct3, rd, 7'b0010011};
        // Shift-immediate forms carry their funct7 in the upper immediate bits.
        if (funct3 == 3'b001 || funct3 == 3'b101) enc[31:25] = funct7;
      end
      3'd2: enc = {imm[11:0], rs1, 3'b010, rd, 7'b0000011};
      3'd3: enc = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
      3'd4: enc = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], 7'b1100011};
      3'd5: enc = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
      3'd6: enc = {imm[31:12], rd, 7'b0110111};
      3'd7: enc = {imm[11:0], rs1, 3'b000, rd, 7'b1100111};
      default: enc = '0;
    endcase
  end

  // Branch and jump offsets must be even; odd ones are consumed but rejected.
  assign misaligned = (iclass == 3'd4 || iclass == 3'd5) && imm[0];

  assign full     = (count == DEPTH_C);
  assign in_ready = (state == IDLE) && !full && !restart;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    word_nxt  = word;
    unique case (state)
      IDLE: begin
        if (restart) begin
          count_nxt = '0;
        end else if (accept) begin
          if (misaligned) begin
            state_nxt = REJECT;
          end else begin
            word_nxt  = enc;
            state_nxt = WRITE;
          end
        end
      end
      WRITE: begin
        state_nxt = IDLE;
        if (restart)    count_nxt = '0;
        else if (!full) count_nxt = count + 1'b1;
      end
      REJECT: begin
        state_nxt = IDLE;
        if (restart) count_nxt = '0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge value regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      word  <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      word  <= word_nxt;
    end
  end

  // Reset masks the strobes combinationally so a pending write is dropped outright.
  assign mem_we    = (state == WRITE) && !rst;
  assign err       = (state == REJECT) && !rst;
  assign mem_addr  = count[AW-1:0];
  assign mem_wdata = word;

endmodule
